cascade_counter: RTL and testbench
==================================

CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the bit width of each stage counter.
REQ-002 The block SHALL have parameter STAGES, default 3, giving the number of chained stages (legal range 1..8).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port en SHALL be an input, 1 bit wide: count enable into stage 0.
REQ-006 Port dir SHALL be an input, 1 bit wide: 0 = count up, 1 = count down; applies to all stages.
REQ-007 Port clr SHALL be an input, 1 bit wide: synchronous clear of all stages.
REQ-008 Port load SHALL be an input, 1 bit wide: synchronous parallel load of all stages.
REQ-009 Port load_val SHALL be an input, STAGES*N bits wide: load data; stage i occupies bits [i*N +: N].
REQ-010 Port max_val SHALL be an input, STAGES*N bits wide: terminal value per stage; stage i occupies bits [i*N +: N]; runtime-changeable.
REQ-011 Port count SHALL be an output, STAGES*N bits wide: registered stage values; stage 0 is least significant.
REQ-012 Port carry SHALL be an output, STAGES bits wide: per-stage rollover/borrow, combinational.
REQ-013 Port wrap SHALL be an output, 1 bit wide: whole-chain rollover, equal to carry[STAGES-1].

Function
REQ-014 Stage enable SHALL be: stage 0 = en; stage i (i>0) = carry[i-1]; all stages update in the same cycle (no per-stage latency).
REQ-015 Stage i is terminal SHALL mean: dir=0 and count_i >= max_i, or dir=1 and count_i == 0.
REQ-016 carry[i] SHALL equal stage-i enable AND stage i terminal, with no clr or load active.
REQ-017 Up mode, enabled stage: non-terminal -> count+1; terminal -> 0.
REQ-018 Down mode, enabled stage: count == 0 -> max_i; 0 < count <= max_i -> count-1; count > max_i -> max_i with carry[i]=0.
REQ-019 Disabled stage SHALL hold its value.
REQ-020 Priority SHALL be rst > clr > load > counting; clr sets every stage to 0; load writes load_val verbatim, including values > max_i.
REQ-021 During clr or load, carry and wrap SHALL be 0.
REQ-022 If max_i == 0, stage i SHALL stay at 0 and pass its enable straight through as carry[i].
REQ-023 A change of max_val or dir SHALL take effect on the next count edge with no extra state; count_i > max_i in up mode wraps to 0 with carry on the next enable.
REQ-024 Arithmetic SHALL be modulo 2^N per stage; no stage ever holds a value not produced by REQ-017/018/020.
REQ-025 In the cycle the whole chain wraps, wrap SHALL be 1 for exactly that cycle.

Reset
REQ-026 Asserting rst low SHALL immediately set every count stage to 0, independent of clk.
REQ-027 While rst is low, carry and wrap SHALL be 0 and all inputs SHALL be ignored.
REQ-028 Counting SHALL resume on the first rising clk edge after rst returns high.
REQ-029 Reset asserted mid-count SHALL discard the chain state; no partial carry SHALL survive reset.

Verification
REQ-030 The bench SHALL cover: N=4, STAGES=3, max all 5, dir=0, en=1 from reset -> count steps 0..5 in stage 0; stage 1 increments on every 6th cycle; wrap is high once at cycle 216 (count 5,5,5 -> 0,0,0).
REQ-031 The bench SHALL cover: dir=1 from count 0,0,0 with max 5 -> next count is 5,5,5 and wrap is high in that cycle.
REQ-032 The bench SHALL cover: load with load_val stage0=9 and max0=5, then dir=0 with en -> stage 0 goes 9 -> 0 and carry[0]=1; dir=1 instead -> stage 0 goes 9 -> 5 and carry[0]=0.
REQ-033 The bench SHALL cover: clr and load asserted together while en=1 -> all stages are 0 and carry=0.
REQ-034 The bench SHALL cover: max1=0 -> stage 1 stays at 0 and carry[1] mirrors carry[0], so stage 2 advances every 6 cycles.
REQ-035 The bench SHALL cover: rst pulsed low between clock edges mid-count -> count is 0 before the next edge, and wrap stays 0 during reset.

Source files
------------

// File: rtl/cascade_counter.sv
// Cascade counter: a chain of STAGES up/down counters, each N bits wide.
// Stage 0 counts when en is high. Every later stage counts when the stage
// below it rolls over (or borrows), and all stages update in the same cycle.
// Each stage has its own runtime terminal value taken from max_val.
module cascade_counter #(
  parameter int N      = 4,
  parameter int STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [STAGES*N-1:0]   load_val,
  input  logic [STAGES*N-1:0]   max_val,
  output logic [STAGES*N-1:0]   count,
  output logic [STAGES-1:0]     carry,
  output logic                  wrap
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [STAGES*N-1:0] count_q;
  logic [STAGES*N-1:0] count_d;
  logic [STAGES-1:0]   carry_c;

  // Walk the chain from stage 0 upward. Each stage works out its next value
  // and its carry, and that carry becomes the enable of the stage above.
  // Clear and load override counting and also suppress every carry.
  // Reset suppresses every carry as well.
  always_comb begin : next_state
    logic         chain_en;
    logic         active;
    logic         term;
    logic [N-1:0] cur;
    logic [N-1:0] mx;
    logic [N-1:0] nxt;

    active   = rst & ~clr & ~load;
    chain_en = en;
    term     = 1'b0;
    cur      = '0;
    mx       = '0;
    nxt      = '0;
    carry_c  = '0;
    count_d  = count_q;

    for (int i = 0; i < STAGES; i++) begin
      cur  = count_q[i*N +: N];
      mx   = max_val[i*N +: N];
      // When counting up, a value above the terminal value still counts as
      // terminal, so a stage that was loaded out of range wraps to 0.
      term = dir ? (cur == '0) : (cur >= mx);

      if (dir) begin
        // When counting down, a value above the terminal value is pulled
        // back to the terminal value. That step is not a borrow.
        if (cur == '0) begin
          nxt = mx;
        end else if (cur <= mx) begin
          nxt = cur - ONE;
        end else begin
          nxt = mx;
        end
      end else begin
        nxt = term ? '0 : cur + ONE;
      end

      carry_c[i] = chain_en & term & active;
      if (chain_en) begin
        count_d[i*N +: N] = nxt;
      end
      chain_en = carry_c[i];
    end

    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end
  end

  // Stage registers. Reset clears them immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign carry = carry_c;
  assign wrap  = carry_c[STAGES-1];

endmodule

// File: tb/tb_cascade_counter.sv
// Directed testbench for cascade_counter with N=4 and STAGES=3.
// Expected values are worked out by hand or come from a small base-6 digit model.
module tb_cascade_counter;

  localparam int N      = 4;
  localparam int STAGES = 3;

  logic              clk;
  logic              rst;
  logic              en;
  logic              dir;
  logic              clr;
  logic              load;
  logic [11:0]       load_val;
  logic [11:0]       max_val;
  logic [11:0]       count;
  logic [2:0]        carry;
  logic              wrap;

  int compCount = 0;
  int failCount = 0;

  cascade_counter #(.N(N), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .count    (count),
    .carry    (carry),
    .wrap     (wrap)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every control input at once.
  task automatic applyStimulus(input logic en_i, input logic dir_i, input logic clr_i,
                               input logic load_i, input logic [11:0] lv_i,
                               input logic [11:0] mv_i);
    en       = en_i;
    dir      = dir_i;
    clr      = clr_i;
    load     = load_i;
    load_val = lv_i;
    max_val  = mv_i;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move forward one rising edge, then stop on the falling edge so outputs can be sampled.
  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Digits of k in base 6, one per stage. Stage 1 can be forced to stay at 0.
  function automatic logic [11:0] model(input int k, input bit mid_zero);
    int d0, d1, d2;
    d0 = k % 6;
    if (mid_zero) begin
      d1 = 0;
      d2 = (k / 6) % 6;
    end else begin
      d1 = (k / 6) % 6;
      d2 = (k / 36) % 6;
    end
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  // Directed sequence.
  initial begin
    logic [2:0] expCarry;
    logic [11:0] m;

    // Hold reset with inputs that would otherwise produce a borrow out of every stage.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h555);
    @(negedge clk);
    checkOutput("reset_count", {20'h0, count}, 32'h0);
    checkOutput("reset_carry", {29'h0, carry}, 32'h0);
    checkOutput("reset_wrap", {31'h0, wrap}, 32'h0);

    // Count up through all 216 states with every terminal value set to 5.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h555);
    rst = 1'b1;
    for (int k = 0; k <= 216; k++) begin
      m = model(k, 1'b0);
      expCarry[0] = (m[3:0] == 4'd5);
      expCarry[1] = expCarry[0] && (m[7:4] == 4'd5);
      expCarry[2] = expCarry[1] && (m[11:8] == 4'd5);
      checkOutput("up_count", {20'h0, count}, {20'h0, m});
      checkOutput("up_carry", {29'h0, carry}, {29'h0, expCarry});
      checkOutput("up_wrap", {31'h0, wrap}, {31'h0, (k == 215)});
      if (k < 216) stepClock();
    end

    // Counting down from 0,0,0 borrows through every stage and reloads 5,5,5.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h555);
    #1;
    checkOutput("down_wrap_pre", {31'h0, wrap}, 32'h1);
    checkOutput("down_carry_pre", {29'h0, carry}, 32'h7);
    stepClock();
    checkOutput("down_count", {20'h0, count}, 32'h555);
    checkOutput("down_wrap_post", {31'h0, wrap}, 32'h0);
    stepClock();
    checkOutput("down_count2", {20'h0, count}, 32'h554);

    // Load a stage 0 value above its terminal value, then count up: it wraps to 0 with a carry.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 12'h009, 12'h555);
    #1;
    checkOutput("load_carry", {29'h0, carry}, 32'h0);
    stepClock();
    checkOutput("load_count", {20'h0, count}, 32'h009);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h009, 12'h555);
    #1;
    checkOutput("over_up_carry", {29'h0, carry}, 32'h1);
    stepClock();
    checkOutput("over_up_count", {20'h0, count}, 32'h010);

    // Load the same value, then count down: it drops to 5 with no borrow.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h009, 12'h555);
    stepClock();
    checkOutput("load_count2", {20'h0, count}, 32'h009);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h009, 12'h555);
    #1;
    checkOutput("over_dn_carry", {29'h0, carry}, 32'h0);
    stepClock();
    checkOutput("over_dn_count", {20'h0, count}, 32'h005);

    // Assert clear and load together: clear wins, and every carry stays low.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h321, 12'h555);
    #1;
    checkOutput("clrload_carry", {29'h0, carry}, 32'h0);
    checkOutput("clrload_wrap", {31'h0, wrap}, 32'h0);
    stepClock();
    checkOutput("clrload_count", {20'h0, count}, 32'h000);

    // Set stage 1's terminal value to 0 so it passes stage 0's carry straight through.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h505);
    for (int k = 0; k <= 36; k++) begin
      m = model(k, 1'b1);
      expCarry[0] = (m[3:0] == 4'd5);
      expCarry[1] = expCarry[0];
      expCarry[2] = expCarry[1] && (m[11:8] == 4'd5);
      checkOutput("max0_count", {20'h0, count}, {20'h0, m});
      checkOutput("max0_carry", {29'h0, carry}, {29'h0, expCarry});
      if (k < 36) stepClock();
    end

    // Pulse reset between clock edges while counting.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h555);
    for (int k = 0; k < 7; k++) stepClock();
    checkOutput("pre_rst_count", {20'h0, count}, 32'h011);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_count", {20'h0, count}, 32'h000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h555);
    #1;
    checkOutput("rst_wrap", {31'h0, wrap}, 32'h0);
    checkOutput("rst_carry", {29'h0, carry}, 32'h0);
    stepClock();
    checkOutput("rst_hold_count", {20'h0, count}, 32'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h555);
    rst = 1'b1;
    #1;
    checkOutput("rst_release_count", {20'h0, count}, 32'h000);
    stepClock();
    checkOutput("resume_count", {20'h0, count}, 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
